// File: rtl/vga_digit_renderer.sv
// Six-digit seven-segment clock overlay on a VGA pixel stream.
// Two-stage pipeline: cell decode, then segment test and colour mux; digits double-buffered per frame.
module vga_digit_renderer #(
   parameter logic [5:0]  FG_RGB = 6'b111100,
   parameter int unsigned Y_TOP  = 176
) (
   input  logic        px_clk,
   input  logic        reset,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        activevideo_in,
   input  logic [9:0]  x_px,
   input  logic [9:0]  y_px,
   input  logic [23:0] digits_in,
   input  logic        digits_valid,
   output logic        digits_busy,
   output logic        hsync,
   output logic        vsync,
   output logic [1:0]  r,
   output logic [1:0]  g,
   output logic [1:0]  b
);

   localparam logic [10:0] YT = 11'(Y_TOP);
   localparam logic [9:0]  CELL_X [6] = '{10'd64, 10'd144, 10'd256, 10'd336, 10'd448, 10'd528};

   logic [23:0] pend_q, disp_q;
   logic        busy_q, vs_prev_q;
   logic        frame_edge;

   logic        hs1_q, vs1_q, av1_q, cell_q, colon_q;
   logic [3:0]  dig_q;
   logic [5:0]  lx_q;
   logic [6:0]  ly_q;

   logic        cell_d, colon_d, in_band;
   logic [3:0]  dig_d;
   logic [5:0]  lx_d;
   logic [6:0]  ly_d;
   logic [10:0] y_ext;

   logic        hs2_q, vs2_q;
   logic [5:0]  rgb_q, rgb_d;
   logic [6:0]  seg;
   logic        lit;

   function automatic logic [6:0] seg_map(input logic [3:0] d);
      // {a,b,c,d,e,f,g}
      case (d)
         4'd0:    seg_map = 7'b1111110;
         4'd1:    seg_map = 7'b0110000;
         4'd2:    seg_map = 7'b1101101;
         4'd3:    seg_map = 7'b1111001;
         4'd4:    seg_map = 7'b0110011;
         4'd5:    seg_map = 7'b1011011;
         4'd6:    seg_map = 7'b1011111;
         4'd7:    seg_map = 7'b1110000;
         4'd8:    seg_map = 7'b1111111;
         4'd9:    seg_map = 7'b1111011;
         default: seg_map = 7'b0000000;
      endcase
   endfunction

   assign frame_edge  = ~vsync_in & vs_prev_q;
   assign digits_busy = busy_q;

   // A strobe on the boundary cycle commits the old pending word and queues the new one.
   always_ff @(posedge px_clk) begin
      if (reset) begin
         pend_q    <= '0;
         disp_q    <= '0;
         busy_q    <= 1'b0;
         vs_prev_q <= 1'b1;
      end else begin
         vs_prev_q <= vsync_in;
         if (frame_edge && busy_q)
            disp_q <= pend_q;
         if (digits_valid) begin
            pend_q <= digits_in;
            busy_q <= 1'b1;
         end else if (frame_edge) begin
            busy_q <= 1'b0;
         end
      end
   end

   always_comb begin
      y_ext   = {1'b0, y_px};
      in_band = (y_ext >= YT) && (y_ext < YT + 11'd128);
      ly_d    = 7'(y_ext - YT);
      cell_d  = 1'b0;
      dig_d   = '0;
      lx_d    = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (in_band && x_px >= CELL_X[i] && x_px <= CELL_X[i] + 10'd63) begin
            cell_d = 1'b1;
            lx_d   = 6'(x_px - CELL_X[i]);
            dig_d  = disp_q[4*(5-i) +: 4];
         end
      end
      colon_d = in_band && ~disp_q[0]
                && ((x_px >= 10'd216 && x_px <= 10'd223) || (x_px >= 10'd408 && x_px <= 10'd415))
                && ((ly_d >= 7'd32 && ly_d <= 7'd39) || (ly_d >= 7'd88 && ly_d <= 7'd95));
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         av1_q   <= 1'b0;
         cell_q  <= 1'b0;
         colon_q <= 1'b0;
         dig_q   <= '0;
         lx_q    <= '0;
         ly_q    <= '0;
      end else begin
         hs1_q   <= hsync_in;
         vs1_q   <= vsync_in;
         av1_q   <= activevideo_in;
         cell_q  <= cell_d;
         colon_q <= colon_d;
         dig_q   <= dig_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
      end
   end

   always_comb begin
      seg = seg_map(dig_q);
      lit = colon_q | (cell_q & (
              (seg[6] && lx_q >= 6'd8  && lx_q <= 6'd55 && ly_q <= 7'd7)
           || (seg[5] && lx_q >= 6'd56 && ly_q >= 7'd8  && ly_q <= 7'd59)
           || (seg[4] && lx_q >= 6'd56 && ly_q >= 7'd68 && ly_q <= 7'd119)
           || (seg[3] && lx_q >= 6'd8  && lx_q <= 6'd55 && ly_q >= 7'd120)
           || (seg[2] && lx_q <= 6'd7  && ly_q >= 7'd68 && ly_q <= 7'd119)
           || (seg[1] && lx_q <= 6'd7  && ly_q >= 7'd8  && ly_q <= 7'd59)
           || (seg[0] && lx_q >= 6'd8  && lx_q <= 6'd55 && ly_q >= 7'd60 && ly_q <= 7'd67)));
      rgb_d = (av1_q && lit) ? FG_RGB : '0;
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
         rgb_q <= '0;
      end else begin
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
         rgb_q <= rgb_d;
      end
   end

   assign hsync     = hs2_q;
   assign vsync     = vs2_q;
   assign {r, g, b} = rgb_q;

endmodule

// File: tb/tb_vga_digit_renderer.sv
// Randomised and directed stimulus for vga_digit_renderer, checked every cycle
// against a geometric model of the digit band and the frame-synchronous digit buffer.
module tb_vga_digit_renderer;

   localparam logic [5:0] FG   = 6'b111100;
   localparam int         YTOP = 176;
   localparam int         ROWS = 12;
   localparam int         PIX  = 200;

   logic        px_clk = 1'b0;
   logic        reset = 1'b1;
   logic        hsync_in = 1'b1, vsync_in = 1'b1, activevideo_in = 1'b0;
   logic [9:0]  x_px = '0, y_px = '0;
   logic [23:0] digits_in = '0;
   logic        digits_valid = 1'b0;
   logic        digits_busy, hsync, vsync;
   logic [1:0]  r, g, b;

   int checks = 0;
   int errors = 0;

   vga_digit_renderer #(.FG_RGB(FG), .Y_TOP(YTOP)) dut (
      .px_clk(px_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .activevideo_in(activevideo_in), .x_px(x_px), .y_px(y_px),
      .digits_in(digits_in), .digits_valid(digits_valid), .digits_busy(digits_busy),
      .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b)
   );

   always #5 px_clk = ~px_clk;

   // Geometry of the digit band, described as lists of lit segment letters and rectangles.
   int    CELLS [6]  = '{64, 144, 256, 336, 448, 528};
   string SEGS  [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
   int    RX0 [7] = '{8, 56, 56, 8, 0, 0, 8};
   int    RX1 [7] = '{55, 63, 63, 55, 7, 7, 55};
   int    RY0 [7] = '{0, 8, 68, 120, 68, 8, 60};
   int    RY1 [7] = '{7, 59, 119, 127, 119, 59, 67};

   function automatic logic [5:0] model_px(input int x, input int y, input logic [23:0] disp);
      int    lx, ly, d, idx;
      string s;
      if (y >= YTOP && y < YTOP + 128) begin
         ly = y - YTOP;
         for (int k = 0; k < 6; k++) begin
            if (x >= CELLS[k] && x < CELLS[k] + 64) begin
               lx = x - CELLS[k];
               d  = int'((disp >> (20 - 4*k)) & 24'hF);
               if (d < 10) begin
                  s = SEGS[d];
                  for (int j = 0; j < s.len(); j++) begin
                     idx = int'(s[j]) - 97;
                     if (lx >= RX0[idx] && lx <= RX1[idx] && ly >= RY0[idx] && ly <= RY1[idx])
                        return FG;
                  end
               end
            end
         end
         if (((x >= 216 && x <= 223) || (x >= 408 && x <= 415)) &&
             ((ly >= 32 && ly <= 39) || (ly >= 88 && ly <= 95)) && (disp % 2 == 0))
            return FG;
      end
      return 6'd0;
   endfunction

   // Model state: previous-cycle input snapshot and the digit buffer.
   logic        p_rst = 1'b1, p_hs = 1'b1, p_vs = 1'b1, p_av = 1'b0;
   int          p_x = 0, p_y = 0;
   logic [23:0] p_disp = '0;
   logic [23:0] m_disp = '0, m_pend = '0;
   logic        m_busy = 1'b0, m_vprev = 1'b1;

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic       e_hs, e_vs, bnd;
      logic [5:0] e_rgb;
      @(posedge px_clk);
      if (reset || p_rst) begin
         e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
      end else begin
         e_hs  = p_hs;
         e_vs  = p_vs;
         e_rgb = p_av ? model_px(p_x, p_y, p_disp) : 6'd0;
      end
      p_rst = reset; p_hs = hsync_in; p_vs = vsync_in; p_av = activevideo_in;
      p_x = int'(x_px); p_y = int'(y_px); p_disp = m_disp;
      if (reset) begin
         m_disp = '0; m_pend = '0; m_busy = 1'b0; m_vprev = 1'b1;
      end else begin
         bnd = !vsync_in && m_vprev;
         if (bnd && m_busy) m_disp = m_pend;
         if (digits_valid) begin
            m_pend = digits_in; m_busy = 1'b1;
         end else if (bnd) begin
            m_busy = 1'b0;
         end
         m_vprev = vsync_in;
      end
      #1;
      chk("hsync", 24'(hsync), 24'(e_hs));
      chk("vsync", 24'(vsync), 24'(e_vs));
      chk("rgb",   24'({r, g, b}), 24'(e_rgb));
      chk("busy",  24'(digits_busy), 24'(m_busy));
      digits_valid = 1'b0;
   endtask

   function automatic logic [23:0] rand_digits();
      logic [23:0] v;
      for (int i = 0; i < 6; i++)
         v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      return v;
   endfunction

   task automatic frame(input logic bval, input logic [23:0] bdata, input int vpct);
      int x, y;
      hsync_in = 1'b1; activevideo_in = 1'b0; vsync_in = 1'b0;
      digits_valid = bval; digits_in = bdata;
      tick();
      tick();
      tick();
      vsync_in = 1'b1;
      tick();
      for (int row = 0; row < ROWS; row++) begin
         for (int c = 0; c < PIX; c++) begin
            x = $urandom_range(0, 639);
            y = $urandom_range(YTOP - 4, YTOP + 131);
            if ($urandom_range(0, 3) == 0) begin
               x = ($urandom_range(0, 1) == 1 ? 404 : 212) + $urandom_range(0, 15);
               y = YTOP + $urandom_range(28, 99);
            end
            x_px = 10'(x); y_px = 10'(y);
            hsync_in = 1'b1;
            activevideo_in = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 999) < vpct) begin
               digits_valid = 1'b1; digits_in = rand_digits();
            end
            tick();
         end
         hsync_in = 1'b0; activevideo_in = 1'b0;
         repeat (4) tick();
         hsync_in = 1'b1;
      end
   endtask

   task automatic probe(input int x, input int y, input logic [5:0] exp, input string nm);
      hsync_in = 1'b1; vsync_in = 1'b1; activevideo_in = 1'b1;
      x_px = 10'(x); y_px = 10'(y);
      tick();
      activevideo_in = 1'b0;
      tick();
      chk(nm, 24'({r, g, b}), 24'(exp));
   endtask

   task automatic send(input logic [23:0] d);
      digits_valid = 1'b1; digits_in = d;
      tick();
      chk("busy_after_send", 24'(digits_busy), 24'd1);
   endtask

   initial begin
      // model pins
      chk("pin_seg_a0",   24'(model_px(72, YTOP, 24'h000000)), 24'(FG));
      chk("pin_g_off0",   24'(model_px(84, YTOP + 64, 24'h000000)), 24'd0);
      chk("pin_colon_od", 24'(model_px(216, YTOP + 32, 24'h123459)), 24'd0);
      chk("pin_one_b",    24'(model_px(124, YTOP + 20, 24'h100000)), 24'(FG));
      chk("pin_one_f",    24'(model_px(68, YTOP + 20, 24'h100000)), 24'd0);
      chk("pin_blank_A",  24'(model_px(94, YTOP + 3, 24'hA00000)), 24'd0);

      repeat (3) tick();
      reset = 1'b0;

      frame(1'b0, 24'h0, 0);
      probe(72, YTOP, FG, "zero_seg_a");
      probe(84, YTOP + 64, 6'd0, "zero_g_off");
      probe(216, YTOP + 32, FG, "colon_lit_even");
      probe(410, YTOP + 95, FG, "colon2_lit_even");

      send(24'h123459);
      probe(84, YTOP + 64, 6'd0, "no_tear_before_commit");
      frame(1'b0, 24'h0, 0);
      chk("commit_123459", m_disp, 24'h123459);
      probe(216, YTOP + 32, 6'd0, "colon_dark_odd");
      probe(124, YTOP + 20, FG, "h10_one_b");
      probe(94, YTOP + 3, 6'd0, "h10_one_no_a");
      probe(174, YTOP + 3, FG, "h1_two_a");
      chk("busy_cleared", 24'(digits_busy), 24'd0);

      send(24'h111111);
      send(24'h222222);
      frame(1'b1, 24'h333333, 0);
      probe(94, YTOP + 63, FG, "two_g");
      chk("busy_held_boundary", 24'(digits_busy), 24'd1);
      frame(1'b0, 24'h0, 0);
      probe(68, YTOP + 100, 6'd0, "three_no_e");
      chk("commit_333333", m_disp, 24'h333333);
      chk("busy_final", 24'(digits_busy), 24'd0);

      send(24'hAF0000);
      frame(1'b0, 24'h0, 0);
      probe(94, YTOP + 3, 6'd0, "blank_A_a");
      probe(204, YTOP + 20, 6'd0, "blank_F_b");
      probe(286, YTOP + 3, FG, "m10_zero_a");
      probe(286, YTOP + 63, 6'd0, "m10_zero_g");

      for (int f = 0; f < 8; f++)
         frame($urandom_range(0, 3) == 0, rand_digits(), 3);

      send(24'h654321);
      hsync_in = 1'b1; activevideo_in = 1'b1; x_px = 10'd72; y_px = 10'(YTOP);
      vsync_in = 1'b0; digits_valid = 1'b1; digits_in = 24'h999999; reset = 1'b1;
      tick();
      chk("rst_hsync", 24'(hsync), 24'd1);
      chk("rst_vsync", 24'(vsync), 24'd1);
      chk("rst_rgb",   24'({r, g, b}), 24'd0);
      chk("rst_busy",  24'(digits_busy), 24'd0);
      reset = 1'b0; vsync_in = 1'b1;
      tick();
      chk("rst_hold", 24'({r, g, b}), 24'd0);
      tick();
      chk("rst_track_zero", 24'({r, g, b}), 24'(FG));
      frame(1'b0, 24'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
